// File: rtl/char_video_pkg.sv
// Shared types and constants for the character-layer tile fetch pipeline.
package char_video_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAITV = 3'd1,
    CODE  = 3'd2,
    WAITC = 3'd3,
    BITS  = 3'd4
  } fetch_state_e;

  localparam logic [9:0] PF_W = 10'd256;
  localparam logic [9:0] PF_H = 10'd256;
  localparam logic [9:0] TILE = 10'd8;

  // Palette colour lives in the upper six bits of the tile code.
  localparam int COLOUR_MSB = 7;
  localparam int COLOUR_LSB = 2;

  function automatic logic [5:0] code_colour(input logic [7:0] code);
    return code[COLOUR_MSB:COLOUR_LSB];
  endfunction

  function automatic logic tile_aligned(input logic [9:0] pos);
    return ((pos & (TILE - 10'd1)) == 10'd0);
  endfunction

endpackage

// File: rtl/char_tile_fetch_if.sv
// Memory-side bus of the tile fetcher: video RAM, character ROM and colour PROM.
interface char_tile_fetch_if;
  logic [9:0]  vram_addr;
  logic [7:0]  vram_q;
  logic [10:0] chr_addr;
  logic        chr_n_cs;
  logic [7:0]  chr_q;
  logic [7:0]  pal_addr;
  logic        pal_n_cs;

  modport master (
    output vram_addr, chr_addr, chr_n_cs, pal_addr, pal_n_cs,
    input  vram_q, chr_q
  );

  modport slave (
    input  vram_addr, chr_addr, chr_n_cs, pal_addr, pal_n_cs,
    output vram_q, chr_q
  );
endinterface

// File: rtl/char_row_shifter.sv
// Glyph row shift register (MSB first) with the colour of the tile being displayed.
module char_row_shifter
  import char_video_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic       load,
  input  logic       shift_en,
  input  logic [7:0] load_bits,
  input  logic [7:0] load_code,
  output logic       pix_bit,
  output logic [5:0] colour
);

  logic [7:0] shift_r;
  logic [5:0] colour_r;

  // Load a fresh glyph row at tile boundaries, otherwise shift one pixel per pix_ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r  <= 8'h00;
      colour_r <= 6'h00;
    end else if (pix_ce && load) begin
      shift_r  <= load_bits;
      colour_r <= code_colour(load_code);
    end else if (pix_ce && shift_en) begin
      shift_r  <= {shift_r[6:0], 1'b0};
    end
  end

  assign pix_bit = shift_r[7];
  assign colour  = colour_r;

endmodule

// File: rtl/char_tile_fetch.sv
// Character-layer tile fetch: prefetches tile code and glyph row, serialises to palette address.
module char_tile_fetch
  import char_video_pkg::*;
#(
  parameter logic [9:0] H_START = 10'd64,
  parameter logic [9:0] V_START = 10'd16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_ce,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  char_tile_fetch_if.master  bus
);

  logic [9:0]   rx_s, ry_s, rx_pre_s, rx_load_s;
  logic         row_ok_s, trig_s, load_s, pix_ok_s;

  fetch_state_e state_r, state_s;
  logic [9:0]   vram_addr_r, vram_addr_s;
  logic [10:0]  chr_addr_r, chr_addr_s;
  logic         chr_n_cs_r, chr_n_cs_s;
  logic [7:0]   next_code_r, next_code_s;
  logic [7:0]   next_bits_r, next_bits_s;
  logic [7:0]   pal_addr_r;
  logic         pal_n_cs_r;
  logic         pix_bit_s;
  logic [5:0]   colour_s;

  // Fetch runs 6 pixels ahead so the row is ready for the load one pixel before the tile.
  assign rx_s      = hpos - H_START;
  assign ry_s      = vpos - V_START;
  assign rx_pre_s  = rx_s + 10'd6;
  assign rx_load_s = rx_s + 10'd1;
  assign row_ok_s  = (ry_s < PF_H);
  assign trig_s    = pix_ce && row_ok_s && (rx_pre_s < PF_W) && tile_aligned(rx_pre_s);
  assign load_s    = pix_ce && row_ok_s && (rx_load_s < PF_W) && tile_aligned(rx_load_s);
  assign pix_ok_s  = row_ok_s && (rx_s < PF_W);

  // Fetch FSM next-state and next register values.
  always_comb begin
    state_s     = state_r;
    vram_addr_s = vram_addr_r;
    chr_addr_s  = chr_addr_r;
    chr_n_cs_s  = chr_n_cs_r;
    next_code_s = next_code_r;
    next_bits_s = next_bits_r;
    case (state_r)
      IDLE: begin
        if (trig_s) begin
          vram_addr_s = {ry_s[7:3], rx_pre_s[7:3]};
          state_s     = WAITV;
        end else begin
          state_s     = IDLE;
        end
      end
      WAITV: state_s = CODE;
      CODE: begin
        next_code_s = bus.vram_q;
        chr_addr_s  = {bus.vram_q, ry_s[2:0]};
        chr_n_cs_s  = 1'b0;
        state_s     = WAITC;
      end
      WAITC: state_s = BITS;
      BITS: begin
        next_bits_s = bus.chr_q;
        chr_n_cs_s  = 1'b1;
        state_s     = IDLE;
      end
      default: begin
        chr_n_cs_s = 1'b1;
        state_s    = IDLE;
      end
    endcase
  end

  // Fetch FSM state and fetch registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      vram_addr_r <= 10'd0;
      chr_addr_r  <= 11'd0;
      chr_n_cs_r  <= 1'b1;
      next_code_r <= 8'd0;
      next_bits_r <= 8'd0;
    end else begin
      state_r     <= state_s;
      vram_addr_r <= vram_addr_s;
      chr_addr_r  <= chr_addr_s;
      chr_n_cs_r  <= chr_n_cs_s;
      next_code_r <= next_code_s;
      next_bits_r <= next_bits_s;
    end
  end

  char_row_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .pix_ce    (pix_ce),
    .load      (load_s),
    .shift_en  (!load_s),
    .load_bits (next_bits_r),
    .load_code (next_code_r),
    .pix_bit   (pix_bit_s),
    .colour    (colour_s)
  );

  // Palette address uses the shifter state from before this pixel's load/shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      pal_addr_r <= 8'd0;
      pal_n_cs_r <= 1'b1;
    end else if (pix_ce) begin
      if (pix_ok_s) begin
        pal_addr_r <= {1'b0, colour_s, pix_bit_s};
        pal_n_cs_r <= 1'b0;
      end else begin
        pal_addr_r <= 8'd0;
        pal_n_cs_r <= 1'b1;
      end
    end
  end

  assign bus.vram_addr = vram_addr_r;
  assign bus.chr_addr  = chr_addr_r;
  assign bus.chr_n_cs  = chr_n_cs_r;
  assign bus.pal_addr  = pal_addr_r;
  assign bus.pal_n_cs  = pal_n_cs_r;

endmodule

// File: tb/tb_char_tile_fetch.sv
// Directed bench for char_tile_fetch with video RAM and character ROM models.
module tb_char_tile_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_ce;
  logic [9:0] hpos, vpos;

  always #5 clk = ~clk;

  char_tile_fetch_if bus();

  char_tile_fetch #(.H_START(10'd64), .V_START(10'd16)) dut (
    .clk    (clk),
    .reset  (reset),
    .pix_ce (pix_ce),
    .hpos   (hpos),
    .vpos   (vpos),
    .bus    (bus)
  );

  logic [7:0] vram [1024];
  logic [7:0] crom [2048];

  // Registered-read memory models; the ROM only updates while selected.
  always @(posedge clk) begin
    bus.vram_q <= vram[bus.vram_addr];
    if (!bus.chr_n_cs) bus.chr_q <= crom[bus.chr_addr];
  end

  int total = 0;
  int bad   = 0;

  logic [7:0]  cap_pal [272];
  logic        cap_cs  [272];
  logic [9:0]  f_vaddr [40];
  logic [10:0] f_caddr [40];
  int          nfetch, hold_err, cs_low_pix;

  typedef struct {
    logic [9:0]  v;
    int          div;
    int          fidx;
    logic [9:0]  va;
    logic [10:0] ca;
    int          base_rx;
    logic [63:0] pal;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_line(input logic [9:0] v, input int div);
    logic       prev_cs;
    logic [7:0] held;
    int         rx;
    vpos = v;
    nfetch = 0; hold_err = 0; cs_low_pix = 0;
    held = 8'h00;
    prev_cs = bus.chr_n_cs;
    for (int i = 0; i < 272; i++) begin
      cap_pal[i] = 8'hEE;
      cap_cs[i]  = 1'b0;
    end
    for (int h = 0; h < 400; h++) begin
      for (int d = 0; d < div; d++) begin
        hpos   = h[9:0];
        pix_ce = (d == 0);
        @(posedge clk); #1;
        if (d == 0) begin
          held = bus.pal_addr;
          rx = h - 64;
          if (rx >= -8 && rx < 264) begin
            cap_pal[rx + 8] = bus.pal_addr;
            cap_cs[rx + 8]  = bus.pal_n_cs;
          end
          if (!bus.pal_n_cs) cs_low_pix++;
        end else if (bus.pal_addr != held) begin
          hold_err++;
        end
        if (prev_cs && !bus.chr_n_cs) begin
          if (nfetch < 40) begin
            f_vaddr[nfetch] = bus.vram_addr;
            f_caddr[nfetch] = bus.chr_addr;
          end
          nfetch++;
        end
        prev_cs = bus.chr_n_cs;
      end
    end
    pix_ce = 1'b0;
  endtask

  task automatic check_line(input vec_t t);
    int last_va;
    logic [7:0] exp_b;
    logic [63:0] pal;
    pal = t.pal;
    last_va = ((int'(t.v) - 16) / 8) * 32 + 31;
    chk("fetch_count", nfetch, 32);
    chk("vram_addr", f_vaddr[t.fidx], t.va);
    chk("chr_addr", f_caddr[t.fidx], t.ca);
    for (int i = 0; i < 8; i++) begin
      exp_b = pal[63 - 8*i -: 8];
      chk($sformatf("pal_addr_rx%0d", t.base_rx + i), cap_pal[t.base_rx + 8 + i], exp_b);
      chk($sformatf("pal_n_cs_rx%0d", t.base_rx + i), cap_cs[t.base_rx + 8 + i], 0);
    end
    chk("pal_n_cs_rx-1", cap_cs[7], 1);
    chk("pal_n_cs_rx255", cap_cs[255 + 8], 0);
    chk("pal_n_cs_rx256", cap_cs[256 + 8], 1);
    chk("pal_addr_rx256", cap_pal[256 + 8], 0);
    chk("vram_addr_after_col31", bus.vram_addr, last_va);
    chk("pal_hold", hold_err, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) vram[i] = 8'h00;
    for (int i = 0; i < 2048; i++) crom[i] = 8'h00;
    vram[10'h000] = 8'h41;  crom[11'h208] = 8'hA5;
    vram[10'h025] = 8'h9C;  crom[11'h4E2] = 8'hF0;
    vram[10'h3FF] = 8'hFF;  crom[11'h7FF] = 8'h81;

    tbl[0] = '{10'd16,  1, 0,  10'h000, 11'h208, 0,   64'h21_20_21_20_20_21_20_21};
    tbl[1] = '{10'd16,  4, 0,  10'h000, 11'h208, 0,   64'h21_20_21_20_20_21_20_21};
    tbl[2] = '{10'd26,  1, 5,  10'h025, 11'h4E2, 40,  64'h4F_4F_4F_4F_4E_4E_4E_4E};
    tbl[3] = '{10'd271, 1, 31, 10'h3FF, 11'h7FF, 248, 64'h7F_7E_7E_7E_7E_7E_7E_7F};

    reset = 1'b1; pix_ce = 1'b0; hpos = 10'd0; vpos = 10'd16;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Trigger the column-5 fetch, then reset while it is in flight.
    vpos = 10'd26; hpos = 10'd98; pix_ce = 1'b1;
    @(posedge clk); #1;
    chk("trigger_vram_addr", bus.vram_addr, 10'h025);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hpos = 10'd99 + 10'(i);
      @(posedge clk); #1;
    end
    reset = 1'b0; pix_ce = 1'b0;
    chk("rst_chr_n_cs", bus.chr_n_cs, 1);
    chk("rst_pal_n_cs", bus.pal_n_cs, 1);
    chk("rst_pal_addr", bus.pal_addr, 0);
    chk("rst_vram_addr", bus.vram_addr, 0);

    for (int k = 0; k < 4; k++) begin
      run_line(tbl[k].v, tbl[k].div);
      check_line(tbl[k]);
    end

    // Line below the playfield: nothing fetched, nothing displayed.
    run_line(10'd272, 1);
    chk("blank_fetches", nfetch, 0);
    chk("blank_pal_cs_low", cs_low_pix, 0);
    chk("blank_chr_n_cs", bus.chr_n_cs, 1);
    chk("blank_vram_addr", bus.vram_addr, 10'h3FF);

    // Reset landing between CODE and BITS of a column-0 fetch.
    vpos = 10'd16; hpos = 10'd58; pix_ce = 1'b1;
    @(posedge clk); #1;
    pix_ce = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midfetch_chr_n_cs_low", bus.chr_n_cs, 0);
    chk("midfetch_chr_addr", bus.chr_addr, 11'h208);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midfetch_rst_chr_n_cs", bus.chr_n_cs, 1);
    run_line(10'd16, 1);
    check_line(tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
